// File: rtl/usb_protocol_controller.sv
// usb_protocol_controller: sequences the shared endpoint buffer between USB RX, USB TX and the AHB slave
module usb_protocol_controller #(
    parameter int TIMEOUT   = 200,
    parameter int TIMEOUT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_packet_valid,
    input  logic [2:0] rx_packet,
    input  logic       rx_data_done,
    input  logic       rx_packet_error,
    input  logic       tx_done,
    input  logic [6:0] buffer_occupancy,
    input  logic [6:0] tx_packet_data_size,
    input  logic       buffer_reserved,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       clear,
    output logic       tx_start,
    output logic [2:0] tx_packet
);
    typedef enum logic [3:0] {IDLE, RX_WAIT, RX_DATA, RX_ACK, RX_NAK, RX_ERR, TX_DATA, TX_WAIT, TX_NAK} state_t;
    localparam logic [2:0] PID_OUT = 3'd1, PID_IN = 3'd2, PID_DATA = 3'd3, PID_ACK = 3'd4;
    localparam logic [2:0] TXP_NONE = 3'd0, TXP_DATA0 = 3'd1, TXP_DATA1 = 3'd2, TXP_ACK = 3'd3, TXP_NAK = 3'd4;
    state_t state, next;
    logic [TIMEOUT_W-1:0] cnt;
    logic toggle;
    logic timeout, out_ok, in_ok, is_out, is_in;
    assign timeout = cnt == TIMEOUT_W'(TIMEOUT - 1);
    assign is_out  = rx_packet_valid && rx_packet == PID_OUT;
    assign is_in   = rx_packet_valid && rx_packet == PID_IN;
    assign out_ok  = !buffer_reserved && buffer_occupancy == 7'd0;
    assign in_ok   = tx_packet_data_size != 7'd0 && buffer_occupancy == tx_packet_data_size && !buffer_reserved;
    assign rx_transfer_active = state inside {RX_WAIT, RX_DATA, RX_ACK};
    assign tx_transfer_active = state inside {TX_DATA, TX_WAIT};
    assign tx_packet = state == RX_ACK ? TXP_ACK :
                       state inside {RX_NAK, TX_NAK} ? TXP_NAK :
                       state == TX_DATA ? (toggle ? TXP_DATA1 : TXP_DATA0) : TXP_NONE;
    // next-state decode and the combinational clear pulse
    always_comb begin
        next  = state;
        clear = 1'b0;
        case (state)
            IDLE: begin
                if (is_out) begin
                    next  = out_ok ? RX_WAIT : RX_NAK;
                    clear = out_ok;
                end else if (is_in) next = in_ok ? TX_DATA : TX_NAK;
            end
            RX_WAIT: begin
                if (rx_packet_valid) next = rx_packet == PID_DATA ? RX_DATA : RX_ERR;
                else if (timeout) next = RX_ERR;
            end
            RX_DATA: next = rx_packet_error ? RX_ERR : rx_data_done ? RX_ACK : RX_DATA;
            RX_ACK, RX_NAK, TX_NAK: next = tx_done ? IDLE : state;
            RX_ERR: begin
                next  = IDLE;
                clear = 1'b1;
            end
            TX_DATA: next = tx_done ? TX_WAIT : TX_DATA;
            TX_WAIT: begin
                if (rx_packet_valid) begin
                    next  = IDLE;
                    clear = rx_packet == PID_ACK;
                end else if (timeout) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
    // state, timeout counter, data toggle and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            toggle        <= 1'b0;
            tx_start      <= 1'b0;
            rx_data_ready <= 1'b0;
            rx_error      <= 1'b0;
            tx_error      <= 1'b0;
        end else begin
            state    <= next;
            cnt      <= next != state ? '0 : &cnt ? cnt : cnt + 1'b1;
            tx_start <= next != state && next inside {RX_ACK, RX_NAK, TX_DATA, TX_NAK};
            if (state == IDLE && buffer_occupancy == 7'd0) rx_data_ready <= 1'b0;
            if (state == RX_ACK && tx_done) rx_data_ready <= 1'b1;
            if (state == IDLE && next == RX_WAIT) rx_error <= 1'b0;
            if (state == RX_ERR) rx_error <= 1'b1;
            if (state == TX_WAIT && next == IDLE) tx_error <= !clear;
            if (state == TX_WAIT && clear) toggle <= !toggle;
        end
    end
endmodule

// File: tb/tb_usb_protocol_controller.sv
// tb_usb_protocol_controller: randomized transactions checked against a transaction-level model
module tb_usb_protocol_controller;
    localparam int TO = 200;
    localparam logic [2:0] P_OUT = 3'd1, P_IN = 3'd2, P_DATA = 3'd3, P_ACK = 3'd4, P_NAK = 3'd5;
    logic clk = 1'b0, rst = 1'b1;
    logic rx_packet_valid = 1'b0, rx_data_done = 1'b0, rx_packet_error = 1'b0, tx_done = 1'b0;
    logic [2:0] rx_packet = 3'd0;
    logic [6:0] buffer_occupancy = 7'd0, tx_packet_data_size = 7'd0;
    logic buffer_reserved = 1'b0;
    logic rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error, clear, tx_start;
    logic [2:0] tx_packet;
    int total = 0, bad = 0, clr_cnt = 0, st_cnt = 0;
    bit m_tog = 0, m_rdr = 0, m_rxe = 0, m_txe = 0;

    usb_protocol_controller dut (
        .clk(clk), .rst(rst), .rx_packet_valid(rx_packet_valid), .rx_packet(rx_packet),
        .rx_data_done(rx_data_done), .rx_packet_error(rx_packet_error), .tx_done(tx_done),
        .buffer_occupancy(buffer_occupancy), .tx_packet_data_size(tx_packet_data_size),
        .buffer_reserved(buffer_reserved), .rx_data_ready(rx_data_ready),
        .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
        .tx_transfer_active(tx_transfer_active), .tx_error(tx_error), .clear(clear),
        .tx_start(tx_start), .tx_packet(tx_packet)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // count clear and tx_start pulses; the two transfer flags must be exclusive
    always @(negedge clk) begin
        if (!rst) begin
            if (clear) clr_cnt++;
            if (tx_start) st_cnt++;
            check("excl", 32'(rx_transfer_active & tx_transfer_active), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [2:0] p);
        @(posedge clk); #1;
        rx_packet_valid = 1'b1;
        rx_packet = p;
        @(posedge clk); #1;
        rx_packet_valid = 1'b0;
        rx_packet = 3'd0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic handshake(input string tag, input logic [2:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 10);
        check({tag, "_start"}, 32'(tx_start), 1);
        check({tag, "_pkt"}, 32'(tx_packet), 32'(exp));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        pulse_done();
    endtask

    task automatic settle_check(input string tag, input int c0, input int s0, input int ec, input int es);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_clears"}, clr_cnt - c0, ec);
        check({tag, "_starts"}, st_cnt - s0, es);
        check({tag, "_rdr"}, 32'(rx_data_ready), 32'(m_rdr));
        check({tag, "_rxe"}, 32'(rx_error), 32'(m_rxe));
        check({tag, "_txe"}, 32'(tx_error), 32'(m_txe));
        check({tag, "_pkt_none"}, 32'(tx_packet), 0);
        check({tag, "_idle"}, 32'({rx_transfer_active, tx_transfer_active}), 0);
    endtask

    task automatic do_out();
        int c0, s0, ec, es, n, kind;
        logic [6:0] occ;
        logic res;
        occ = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 64)) : 7'd0;
        res = $urandom_range(0, 4) == 0;
        buffer_occupancy = occ;
        buffer_reserved = res;
        if (occ == 0) m_rdr = 0;
        repeat (2) @(posedge clk);
        c0 = clr_cnt;
        s0 = st_cnt;
        ec = 0;
        es = 0;
        strobe(P_OUT);
        if (res || occ != 0) begin
            handshake("out_nak", 3'd4);
            es = 1;
        end else begin
            m_rdr = 0;
            m_rxe = 0;
            ec = 1;
            @(negedge clk);
            check("out_rx_act", 32'(rx_transfer_active), 1);
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                n = 1;
                while (!clear && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                check("out_timeout_cycles", n, TO + 1);
                m_rxe = 1;
                ec = 2;
            end else if (kind == 1) begin
                repeat ($urandom_range(0, 10)) @(posedge clk);
                strobe(P_IN);
                m_rxe = 1;
                ec = 2;
            end else begin
                repeat ($urandom_range(0, 10)) @(posedge clk);
                strobe(P_DATA);
                repeat ($urandom_range(0, 20)) @(posedge clk);
                @(posedge clk); #1;
                if (kind == 2) begin
                    rx_packet_error = 1'b1;
                    rx_data_done = 1'($urandom_range(0, 1));
                end else rx_data_done = 1'b1;
                @(posedge clk); #1;
                rx_packet_error = 1'b0;
                rx_data_done = 1'b0;
                if (kind == 2) begin
                    m_rxe = 1;
                    ec = 2;
                end else begin
                    buffer_occupancy = 7'($urandom_range(1, 64));
                    handshake("out_ack", 3'd3);
                    m_rdr = 1;
                    es = 1;
                end
            end
        end
        settle_check("out", c0, s0, ec, es);
    endtask

    task automatic do_in();
        int c0, s0, ec, es, resp;
        logic [6:0] occ, sz;
        logic res;
        sz = 7'($urandom_range(0, 64));
        occ = ($urandom_range(0, 3) != 0) ? sz : 7'($urandom_range(0, 64));
        res = $urandom_range(0, 5) == 0;
        tx_packet_data_size = sz;
        buffer_occupancy = occ;
        buffer_reserved = res;
        if (occ == 0) m_rdr = 0;
        repeat (2) @(posedge clk);
        c0 = clr_cnt;
        s0 = st_cnt;
        ec = 0;
        es = 1;
        strobe(P_IN);
        if (sz != 0 && occ == sz && !res) begin
            handshake("in_data", m_tog ? 3'd2 : 3'd1);
            @(negedge clk);
            check("in_tx_act", 32'(tx_transfer_active), 1);
            resp = $urandom_range(0, 3);
            repeat ($urandom_range(0, 10)) @(posedge clk);
            if (resp <= 1) begin
                strobe(P_ACK);
                m_tog = !m_tog;
                m_txe = 0;
                ec = 1;
            end else if (resp == 2) begin
                strobe(P_NAK);
                m_txe = 1;
            end else begin
                repeat (TO + 5) @(posedge clk);
                m_txe = 1;
            end
        end else handshake("in_nak", 3'd4);
        settle_check("in", c0, s0, ec, es);
    endtask

    task automatic do_other();
        int c0, s0;
        logic [2:0] p;
        p = 3'($urandom_range(3, 8));
        buffer_reserved = 1'($urandom_range(0, 1));
        if (buffer_occupancy == 0) m_rdr = 0;
        repeat (2) @(posedge clk);
        c0 = clr_cnt;
        s0 = st_cnt;
        strobe(p);
        settle_check("other", c0, s0, 0, 0);
    endtask

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_pkt", 32'(tx_packet), 0);
        check("rst_flags", 32'({rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error, clear, tx_start}), 0);
        check("rst_clears", clr_cnt, 0);
        check("rst_starts", st_cnt, 0);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0, 1: do_out();
                2, 3: do_in();
                default: do_other();
            endcase
        end
        buffer_occupancy = 7'd0;
        buffer_reserved = 1'b0;
        repeat (2) @(posedge clk);
        c0 = clr_cnt;
        strobe(P_OUT);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_flags", 32'({rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error, clear, tx_start}), 0);
        check("midrst_pkt", 32'(tx_packet), 0);
        check("midrst_clears", clr_cnt - c0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
